// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one N-bit decoder among 2**N requesters.
// Define RR_ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module rr_decoder_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**N-1:0] req,
    input  logic            done,
    output logic            dec_en,
    output logic [N-1:0]    dec_idx,
    output logic [2**N-1:0] gnt,
    output logic            busy,
    output logic            timeout
);

    localparam int NR = 2**N;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          en_q, en_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [NR-1:0] gnt_q, gnt_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic          found;
    logic [N-1:0]  win;
    logic          release_c;

    // First requester at or after ptr, wrapping through the index space.
    always_comb begin
        logic [N-1:0] cand;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NR; k++) begin
            cand = ptr_q + N'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign release_c = done || !req[idx_q];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic          expire;

    assign expire = (cnt_q == CW'(MAX_HOLD - 1));
`else
    logic expire;

    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    en_d    = 1'b1;
                    idx_d   = win;
                    gnt_d   = {{(NR-1){1'b0}}, 1'b1} << win;
                    ptr_d   = win + 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_GRANT: begin
                // A genuine release beats a coincident expiry.
                if (release_c || expire) begin
                    state_d = S_GAP;
                    en_d    = 1'b0;
                    gnt_d   = '0;
`ifdef RR_ARB_TIMEOUT_EN
                    to_d    = !release_c;
`endif
                end
`ifdef RR_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign dec_en  = en_q;
    assign dec_idx = idx_q;
    assign gnt     = gnt_q;
    assign busy    = (state_q != S_IDLE);
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed plus randomized check of rr_decoder_arbiter (N=2, MAX_HOLD=4)
// against a cycle-level reference model of the arbitration rules.
module tb_rr_decoder_arbiter;

    localparam int N  = 2;
    localparam int NR = 4;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic          done;
    logic          dec_en;
    logic [N-1:0]  dec_idx;
    logic [NR-1:0] gnt;
    logic          busy;
    logic          timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_owner;
    bit m_gap;
    int m_ptr;
    int m_hold;
    int m_last;
    bit m_to;

`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    rr_decoder_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .dec_en  (dec_en),
        .dec_idx (dec_idx),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_ptr   = 0;
            m_hold  = 0;
            m_last  = 0;
            m_to    = 1'b0;
        end else if (m_owner >= 0) begin
            m_to = 1'b0;
            if (done || !req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (TO_EN && m_hold == MH) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_to  = 1'b0;
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (m_owner < 0 && req[i]) begin
                    m_owner = i;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_ptr  = (m_owner + 1) % NR;
                m_hold = 1;
            end
        end
    endtask

    task automatic compare();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h0;
        check("gnt", 8'(gnt), eg);
        check("dec_en", 8'(dec_en), 8'(m_owner >= 0));
        check("dec_idx", 8'(dec_idx), 8'(m_last));
        check("busy", 8'(busy), 8'((m_owner >= 0) || m_gap));
        check("timeout", 8'(timeout), 8'(m_to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare();
    endtask

    initial begin
        logic [NR-1:0] rr_exp [5];
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        m_owner = -1;
        m_gap = 1'b0;
        m_ptr = 0;
        m_hold = 0;
        m_last = 0;
        m_to = 1'b0;

        // Reset held with all requesting
        tick();
        tick();
        check("rst_gnt", 8'(gnt), 8'h0);
        check("rst_en", 8'(dec_en), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        rst = 1'b0;
        tick();
        check("first_gnt", 8'(gnt), 8'h01);

        // Round-robin order with done pulses
        for (int g = 0; g < 5; g++) begin
            if (g > 0) tick();
            check("rr_order", 8'(gnt), 8'(rr_exp[g]));
            done = 1'b1;
            tick();
            check("rr_release", 8'(gnt), 8'h0);
            done = 1'b0;
            tick();
            check("rr_gap", 8'(gnt), 8'h0);
        end

        // Wrap and skip: ptr=3 after idx 2, then req 0011 picks idx 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        check("ws_g2", 8'(gnt), 8'h04);
        req = 4'b0011;
        tick();
        check("ws_rel", 8'(gnt), 8'h0);
        tick();
        tick();
        check("ws_wrap", 8'(gnt), 8'h01);

        // Implicit release of owner 1
        req = 4'b0010;
        tick();
        tick();
        tick();
        check("ir_g1", 8'(gnt), 8'h02);
        req = 4'b1001;
        tick();
        check("ir_drop", 8'(gnt), 8'h0);
        check("ir_busy", 8'(busy), 8'h1);
        tick();
        tick();
        check("ir_next", 8'(gnt), 8'h08);

        // Reset mid-grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        check("rm_g2", 8'(gnt), 8'h04);
        rst = 1'b1;
        req = 4'b1111;
        tick();
        check("rm_gnt", 8'(gnt), 8'h0);
        check("rm_to", 8'(timeout), 8'h0);
        rst = 1'b0;
        tick();
        check("rm_scan0", 8'(gnt), 8'h01);

        // Timeout behaviour with idx 2 holding
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        req = 4'b1100;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("to_hold", 8'(gnt), 8'h04);
        end
        tick();
`ifdef RR_ARB_TIMEOUT_EN
        check("to_revoke", 8'(gnt), 8'h0);
        check("to_pulse", 8'(timeout), 8'h1);
        tick();
        check("to_once", 8'(timeout), 8'h0);
        tick();
        check("to_next", 8'(gnt), 8'h08);
`else
        for (int c = 0; c < 10; c++) begin
            check("nto_hold", 8'(gnt), 8'h04);
            check("nto_pulse", 8'(timeout), 8'h0);
            tick();
        end
`endif

        // Randomized traffic against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            req  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) req = req | gnt;
            done = ($urandom_range(0, 9) < 2);
            rst  = ($urandom_range(0, 99) < 2);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
